// File: rtl/vector_alu_pkg.sv
// Shared types for the vector ALU element sequencer.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
// Contents: opcode enum, sequencer FSM states, default-width result FIFO entry.
package vector_alu_pkg;

  // Default element width for the vector datapath.
  localparam int unsigned vdw_c = 32;

  typedef enum logic [1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    MUL = 2'd2
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  // One buffered ALU result plus the end-of-command marker.
  typedef struct packed {
    logic [vdw_c-1:0] data;
    logic             last;
  } res_entry_t;

endpackage

// File: rtl/vector_alu_res_fifo.sv
// Generic 1-read 1-write FIFO with occupancy count; head is presented combinationally.
// Latency: a push is visible at data_o/empty_o the cycle after it is written.
// Backpressure: push is dropped when full unless a pop frees the slot in the same cycle.
// Ports: clk_i/reset_i (async active-low), push_i/data_i write side,
//        pop_i/data_o/empty_o read side, count_o current number of entries.
module vector_alu_res_fifo #(
  parameter  int unsigned width_p = 33,
  parameter  int unsigned els_p   = 4,
  localparam int unsigned aw_lp   = (els_p > 1) ? $clog2(els_p) : 1,
  localparam int unsigned cw_lp   = $clog2(els_p + 1)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               push_i,
  input  logic [width_p-1:0] data_i,
  input  logic               pop_i,
  output logic [width_p-1:0] data_o,
  output logic               empty_o,
  output logic [cw_lp-1:0]   count_o
);

  logic [width_p-1:0] mem_q [els_p];
  logic [aw_lp-1:0]   wptr_q, rptr_q;
  logic [cw_lp-1:0]   count_q;
  logic               full, push_ok, pop_ok;

  // Pointers wrap explicitly so non power-of-two depths work.
  function automatic logic [aw_lp-1:0] ptr_inc(input logic [aw_lp-1:0] p);
    return (p == aw_lp'(els_p - 1)) ? '0 : p + aw_lp'(1);
  endfunction

  assign full    = (count_q == cw_lp'(els_p));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && (!full || pop_i);
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem_q[rptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= ptr_inc(wptr_q);
      if (pop_ok)  rptr_q <= ptr_inc(rptr_q);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + cw_lp'(1);
        2'b01:   count_q <= count_q - cw_lp'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: nothing is read until count_q says it was written.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/vector_alu_seq.sv
// Element sequencer: takes one (op,len) command, issues operand pairs to the ALU one per cycle, buffers results.
// Latency: first result alu_lat_p+1 cycles after first issue; sustained 1 element/cycle; done_v_o one cycle after last pop.
// Backpressure: operands are accepted only while FIFO entries + in-flight ALU ops < fifo_els_p; the ALU is never stalled.
// Ports: cmd_* command handshake; opnd_* operand-pair stream from the register file;
//        alu_* operands out / result+flags in; res_* result stream; done_v_o + sum_* per-command summary.
module vector_alu_seq
  import vector_alu_pkg::*;
#(
  parameter  int unsigned vdw_p      = vdw_c,
  parameter  int unsigned op_width_p = 2,
  parameter  int unsigned els_p      = 16,
  parameter  int unsigned alu_lat_p  = 1,
  parameter  int unsigned fifo_els_p = 4,
  localparam int unsigned lw_lp      = $clog2(els_p + 1)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  // command
  input  logic                  cmd_v_i,
  output logic                  cmd_ready_o,
  input  logic [op_width_p-1:0] cmd_op_i,
  input  logic [lw_lp-1:0]      cmd_len_i,
  // operand pairs
  input  logic                  opnd_v_i,
  output logic                  opnd_ready_o,
  input  logic [vdw_p-1:0]      opnd_a_i,
  input  logic [vdw_p-1:0]      opnd_b_i,
  // ALU interface
  output logic [vdw_p-1:0]      alu_a_o,
  output logic [vdw_p-1:0]      alu_b_o,
  output logic [op_width_p-1:0] alu_op_o,
  input  logic [vdw_p-1:0]      alu_result_i,
  input  logic                  alu_flag_overflow_i,
  input  logic                  alu_flag_zero_i,
  input  logic                  alu_flag_negative_i,
  // results
  output logic                  res_v_o,
  input  logic                  res_ready_i,
  output logic [vdw_p-1:0]      res_data_o,
  output logic                  res_last_o,
  // completion
  output logic                  done_v_o,
  output logic                  sum_overflow_o,
  output logic                  sum_zero_o,
  output logic                  sum_negative_o
);

  localparam int unsigned       cw_lp      = $clog2(fifo_els_p + 1);
  localparam logic [lw_lp-1:0]  max_len_lp = lw_lp'(els_p);

  // Same layout as vector_alu_pkg::res_entry_t, sized by vdw_p.
  typedef struct packed {
    logic [vdw_p-1:0] data;
    logic             last;
  } entry_t;

  seq_state_e state_q, state_d;

  logic [op_width_p-1:0] op_q;
  logic [lw_lp-1:0]      len_q, issued_q, len_clamped;
  logic [alu_lat_p-1:0]  tag_vld_q, tag_last_q;
  logic                  ovf_q, zero_q, neg_q;

  logic                  cmd_rdy, accept;
  logic                  opnd_rdy, issue, last_issue;
  logic                  credit_ok;
  int unsigned           inflight;
  logic                  tag_exit;
  logic                  pop;

  entry_t                push_ent, head;
  logic                  fifo_empty;
  logic [cw_lp-1:0]      fifo_count;

  // ---------------------------------------------------------------------------
  // Handshake and issue control
  // ---------------------------------------------------------------------------
  assign cmd_rdy     = (state_q == IDLE);
  assign accept      = cmd_v_i && cmd_rdy;
  assign len_clamped = (cmd_len_i > max_len_lp) ? max_len_lp : cmd_len_i;

  // Every issued element already owns a FIFO slot, counting the ones still
  // inside the ALU; that is what lets the ALU run without a stall input.
  always_comb begin
    inflight = 0;
    for (int i = 0; i < int'(alu_lat_p); i++) begin
      inflight = inflight + 32'(tag_vld_q[i]);
    end
  end

  assign credit_ok  = (32'(fifo_count) + inflight) < fifo_els_p;
  assign opnd_rdy   = (state_q == RUN) && (issued_q < len_q) && credit_ok;
  assign issue      = opnd_v_i && opnd_rdy;
  assign last_issue = issue && ((issued_q + lw_lp'(1)) == len_q);

  // The tag leaving the pipe lines up with the ALU result for that element.
  assign tag_exit = tag_vld_q[alu_lat_p-1];
  assign push_ent = '{data: alu_result_i, last: tag_last_q[alu_lat_p-1]};
  assign pop      = !fifo_empty && res_ready_i;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (len_clamped == '0) ? DONE : RUN;
      RUN:     if (last_issue) state_d = DRAIN;
      DRAIN:   if (pop && head.last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    cmd_ready_o    = cmd_rdy;
    opnd_ready_o   = opnd_rdy;
    done_v_o       = 1'b0;
    sum_overflow_o = 1'b0;
    sum_zero_o     = 1'b0;
    sum_negative_o = 1'b0;
    if (state_q == DONE) begin
      done_v_o       = 1'b1;
      sum_overflow_o = ovf_q;
      sum_zero_o     = zero_q;
      sum_negative_o = neg_q;
    end
  end

  // Idle ALU inputs are forced to zero so the ALU sees no stale operands.
  assign alu_a_o  = issue ? opnd_a_i : '0;
  assign alu_b_o  = issue ? opnd_b_i : '0;
  assign alu_op_o = op_q;

  assign res_v_o    = !fifo_empty;
  assign res_data_o = fifo_empty ? '0 : head.data;
  assign res_last_o = !fifo_empty && head.last;

  // ---------------------------------------------------------------------------
  // Command registers, issue counter, tag pipe, summary accumulators
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      op_q       <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      tag_vld_q  <= '0;
      tag_last_q <= '0;
      ovf_q      <= 1'b0;
      zero_q     <= 1'b0;
      neg_q      <= 1'b0;
    end else begin
      if (accept) begin
        op_q     <= cmd_op_i;
        len_q    <= len_clamped;
        issued_q <= '0;
        ovf_q    <= 1'b0;
        zero_q   <= 1'b1;
        neg_q    <= 1'b0;
      end else begin
        if (issue) issued_q <= issued_q + lw_lp'(1);
        if (tag_exit) begin
          ovf_q  <= ovf_q  | alu_flag_overflow_i;
          zero_q <= zero_q & alu_flag_zero_i;
          neg_q  <= neg_q  | alu_flag_negative_i;
        end
      end

      for (int i = int'(alu_lat_p) - 1; i > 0; i--) begin
        tag_vld_q[i]  <= tag_vld_q[i-1];
        tag_last_q[i] <= tag_last_q[i-1];
      end
      tag_vld_q[0]  <= issue;
      tag_last_q[0] <= last_issue;
    end
  end

  // ---------------------------------------------------------------------------
  // Result buffer
  // ---------------------------------------------------------------------------
  vector_alu_res_fifo #(
    .width_p ($bits(entry_t)),
    .els_p   (fifo_els_p)
  ) u_res_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (tag_exit),
    .data_i  (push_ent),
    .pop_i   (pop),
    .data_o  (head),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

endmodule

// File: doc/vector_alu_seq.md
Name: vector_alu_seq

Overview:
Element sequencer that drives the vector ALU. It accepts one vector command (op, length) and pulls operand pairs from the register-file read stream. It issues one element per cycle to the ALU and captures results after the fixed ALU latency into a small result FIFO. Results go out on a valid/ready stream, and the block reports per-command summary flags at completion. It sits between the vector register file read port and the writeback path.

Parameters:
vdw_p, 32, element data width
op_width_p, 2, ALU opcode width (0 add, 1 sub, 2 mul)
els_p, 16, maximum vector length; len width lw = $clog2(els_p+1)
alu_lat_p, 1, ALU cycles from operand presentation to result_o/flags valid
fifo_els_p, 4, result FIFO depth; must be >= alu_lat_p+1

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous active-low reset
cmd_v_i / cmd_ready_o  in/out  1/1  command handshake
cmd_op_i / cmd_len_i  in  op_width_p / lw  opcode, element count
opnd_v_i / opnd_ready_o  in/out  1/1  operand-pair handshake
opnd_a_i / opnd_b_i  in  vdw_p each  signed operands
alu_a_o / alu_b_o / alu_op_o  out  vdw_p / vdw_p / op_width_p  to ALU
alu_result_i  in  vdw_p  ALU result
alu_flag_overflow_i / alu_flag_zero_i / alu_flag_negative_i  in  1 each  ALU flags
res_v_o / res_ready_i  out/in  1/1  result handshake
res_data_o / res_last_o  out  vdw_p / 1  result, last element of command
done_v_o  out  1  one-cycle completion pulse
sum_overflow_o / sum_zero_o / sum_negative_o  out  1 each  summary flags, valid when done_v_o=1

Behaviour:
- Reset (reset_i=0, async): state IDLE. All outputs 0 except cmd_ready_o=1. FIFO emptied, tag pipe cleared, counters 0, summary flags 0. Reset asserted mid-command abandons the command; no done pulse.
- FSM IDLE: cmd_ready_o=1. On cmd_v_i, latch op and len (len>els_p clamps to els_p) and clear summary accumulators (ovf=0, zero=1, neg=0). len==0 -> DONE; else -> RUN.
- RUN: opnd_ready_o = (issued<len) && (credit>0). credit = fifo_els_p - fifo_count - inflight.
- Issue = opnd_v_i && opnd_ready_o. alu_a_o/alu_b_o are opnd_a_i/opnd_b_i when issuing, else 0. alu_op_o holds the latched op for the whole command.
- The issue bit shifts through an alu_lat_p-deep tag pipe. When the tag exits, push {alu_result_i, last} into the FIFO. Accumulate ovf|=flag_overflow, zero&=flag_zero, neg|=flag_negative.
- On the last issue -> DRAIN.
- DRAIN: no issues. When the result with last=1 pops (res_v_o && res_ready_i && res_last_o) -> DONE.
- DONE: done_v_o=1 for exactly one cycle with the sum_* flags driven. cmd_ready_o=0. Next cycle -> IDLE.
- A new command is never accepted while the previous one still has results in flight or buffered.
- res_v_o = FIFO not empty. Results leave in issue order. The ALU is never stalled; the credit rule guarantees no FIFO overflow under arbitrary res_ready_i.
- Simultaneous FIFO push and pop in one cycle: count unchanged. A push into an empty FIFO is visible on res_v_o the next cycle.
- Throughput: 1 element/cycle when opnd_v_i and res_ready_i are continuously high. First result appears alu_lat_p+1 cycles after the first issue.

Decomposition:
- Package vector_alu_pkg: opcode enum (ADD=0, SUB=1, MUL=2), FSM state enum {IDLE, RUN, DRAIN, DONE}, and a result entry struct {data, last}.
- One sub-module, vector_alu_res_fifo: a parameterised 1r1w FIFO with count output.

Test Plan:
1. op=0, len=3, a={1,2,3}, b={1,2,3}, res_ready_i=1 -> res_data 2,4,6; res_last on 6; done_v_o once; sum_zero=0, sum_negative=0.
2. op=1, len=2, a={10,4}, b={8,10} -> results 2, -6; sum_negative=1. Then op=2, len=2, a={3,11}, b={3,4} -> 9, 44.
3. op=0, len=8, a=b=k for element k, res_ready_i=0 for 10 cycles then 1 -> opnd_ready_o drops after 4 elements held; results 0,2,...,14 in order; no loss or duplication.
4. cmd_len=0 -> done_v_o one cycle later; res_v_o never asserted; sum_zero=1, sum_overflow=0.
5. op=0, len=1, a=32'h7FFFFFFF, b=1 -> res_data 32'h80000000; sum_overflow=1, sum_negative=1.
6. reset_i low mid-RUN after 2 of 5 issues -> all outputs 0 and cmd_ready_o=1 immediately; a fresh len=1 command (0+0) completes with res_data 0 and sum_zero=1.
